// File: rtl/pwm_multichannel_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and constants for the multi-channel PWM generator.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Alignment of the PWM pulse within a period
  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_t;

  // Period counter states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } pwm_state_t;

  // Reset period is all ones at any width; replicate this bit N times
  localparam logic c_period_rst_bit = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pwm_multichannel_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multichannel_generator_if
// Brief    : Config/run bus and PWM outputs of the multi-channel generator.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_multichannel_generator_if #(
  parameter int N  = 8,
  parameter int CH = 4
);
  localparam int AW = $clog2(CH + 1);

  logic          en;
  logic          centerMode;
  logic          cfgWe;
  logic [AW-1:0] cfgAddr;
  logic [N-1:0]  cfgData;
  logic [CH-1:0] pwm;
  logic          periodStart;

  // Register/config logic side
  modport master (
    output en, centerMode, cfgWe, cfgAddr, cfgData,
    input  pwm, periodStart
  );

  // Generator side
  modport slave (
    input  en, centerMode, cfgWe, cfgAddr, cfgData,
    output pwm, periodStart
  );
endinterface
`default_nettype wire

// File: rtl/pwm_multichannel_generator_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Brief    : One PWM channel: double-buffered duty and registered compare.
//            count_i/run_i are the values the counter takes on the next edge,
//            so the flopped output lines up with the count it reflects.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run_i,
  input  logic [N-1:0] count_i,
  input  logic         load_i,
  input  logic         we_i,
  input  logic [N-1:0] data_i,
  output logic         pwm_o
);

  logic [N-1:0] duty_sh_q,  duty_sh_d;
  logic [N-1:0] duty_act_q, duty_act_d;
  logic         pwm_q,      pwm_d;

  // Shadow write, write-through on load, and compare against the next count
  always_comb begin
    duty_sh_d  = we_i ? data_i : duty_sh_q;
    duty_act_d = load_i ? duty_sh_d : duty_act_q;
    pwm_d      = run_i && (count_i < duty_act_d);
  end

  // Duty registers and the glitch-free output flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multichannel_generator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multichannel_generator
// Brief    : CH-channel PWM generator sharing one up / up-down period counter.
//            Period, duties and mode are double-buffered and load together at
//            period boundaries (or continuously while idle).
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multichannel_generator
  import pwm_pkg::*;
#(
  parameter int N  = 8,
  parameter int CH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  pwm_multichannel_generator_if.slave  bus
);

  localparam int AW = $clog2(CH + 1);

  pwm_state_t    state_q,      state_d;
  logic [N-1:0]  count_q,      count_d;
  logic [N-1:0]  period_sh_q,  period_sh_d;
  logic [N-1:0]  period_act_q, period_act_d;
  pwm_mode_t     mode_act_q,   mode_act_d;
  logic          period_start_q;

  logic [N-1:0]  w_period_max;
  logic          w_last;
  logic          w_load;
  logic          w_restart;
  logic          w_start;
  logic          w_run;
  logic [CH-1:0] w_pwm;

  // Period shadow write, end-of-period detection and the shared load strobe
  always_comb begin
    period_sh_d = period_sh_q;
    if (bus.cfgWe && (bus.cfgAddr == AW'(CH))) begin
      period_sh_d = bus.cfgData;
    end
    w_period_max = period_act_q - N'(1);
    case (state_q)
      UP:      w_last = (mode_act_q == EDGE) && (count_q == w_period_max);
      DOWN:    w_last = (count_q == '0);
      default: w_last = 1'b0;
    endcase
    // Idle counts as a boundary so config keeps tracking the shadows
    w_load       = (state_q == IDLE) || !bus.en || (period_act_q == '0) || w_last;
    period_act_d = w_load ? period_sh_d : period_act_q;
    mode_act_d   = w_load ? pwm_mode_t'(bus.centerMode) : mode_act_q;
  end

  // Counter FSM next state; a restart uses the period being loaded this cycle
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    w_start   = 1'b0;
    w_restart = (state_q == IDLE) || w_last || (period_act_q == '0);
    if (!bus.en) begin
      state_d = IDLE;
      count_d = '0;
    end else if (w_restart) begin
      count_d = '0;
      if (period_act_d != '0) begin
        state_d = UP;
        w_start = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q == UP) begin
      // Only center mode reaches the top without restarting; hold it once
      if (count_q == w_period_max) begin
        state_d = DOWN;
      end else begin
        count_d = count_q + N'(1);
      end
    end else begin
      count_d = count_q - N'(1);
    end
    w_run = (state_d != IDLE);
  end

  // Counter, active config and period-start flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      period_sh_q    <= {N{c_period_rst_bit}};
      period_act_q   <= {N{c_period_rst_bit}};
      mode_act_q     <= EDGE;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      period_sh_q    <= period_sh_d;
      period_act_q   <= period_act_d;
      mode_act_q     <= mode_act_d;
      period_start_q <= w_start;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic w_we;
    assign w_we = bus.cfgWe && (bus.cfgAddr == AW'(gi));

    pwm_channel #(
      .N (N)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .run_i   (w_run),
      .count_i (count_d),
      .load_i  (w_load),
      .we_i    (w_we),
      .data_i  (bus.cfgData),
      .pwm_o   (w_pwm[gi])
    );
  end

  assign bus.pwm         = w_pwm;
  assign bus.periodStart = period_start_q;

endmodule
`default_nettype wire

// File: doc/pwm_multichannel_generator.md
# pwm_multichannel_generator

Multi-channel, parametrised PWM generator. It is the successor to the single-channel square-wave-based PWM block. CH channels share one period counter. Each channel has its own duty register. Period, duty and alignment mode are double-buffered, so new settings take effect only at a period boundary and the outputs never glitch. It sits between the register/config logic and the pad-facing PWM outputs (motor, LED and fan drives).

## Interface
- N, 8: counter, period and duty width in bits.
- CH, 4: number of PWM channels, at least 1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low holds the generator idle.
- centerMode  in  1  0 = edge-aligned, 1 = center-aligned; sampled into the active config at each load.
- cfgWe  in  1  config write strobe, one write per cycle.
- cfgAddr  in  $clog2(CH+1)  selects the shadow register: 0..CH-1 are the duty registers of channels 0..CH-1; CH is the period register.
- cfgData  in  N  write data.
- pwm  out  CH  PWM outputs, registered.
- periodStart  out  1  one-cycle pulse in the first cycle of every period.

## Operation
- **Shadow registers:** periodSh, dutySh[CH]. cfgWe writes cfgData to the addressed shadow register. Writes to addresses above CH are ignored.
- **Active registers:** periodAct, dutyAct[CH], modeAct.
- **Load event:** all shadows and centerMode are copied to the active registers together. A load occurs:
  - every cycle while en=0 or periodAct=0, and
  - at the end of the last cycle of each period.
- **Write during a load cycle:** the newly written value is loaded directly into the active register (write-through).
- **Counter FSM:** states IDLE, UP, DOWN.
  - IDLE: count=0, pwm=0, no periodStart. The FSM stays in IDLE while en=0 or periodAct=0. Otherwise it goes to UP with count=0.
  - Edge mode (UP only): count runs 0..P-1 and then wraps to 0. One period is P cycles.
  - Center mode: UP runs 0..P-1, then DOWN runs P-1..0, then back to UP. Each endpoint value is held for two cycles. One period is 2P cycles.
  - en falling: the FSM goes to IDLE on the next edge and the current period is abandoned.
- **Compare:** during a cycle with count c, pwm[i] = (c < dutyAct[i]).
  - Edge mode: high for min(D,P) cycles per period. The pulse is left-aligned at period start.
  - Center mode: high for 2·min(D,P) cycles. The pulse is symmetric about the count-0 turnaround (period boundary).
  - D=0 gives a constant low output. D≥P gives a constant high output with no glitch at the wrap.
- **Width rules:** all compares are unsigned N-bit. The counter never exceeds P-1, so it cannot overflow.

## Timing
- **Reset values:** count=0, FSM=IDLE, pwm=0, periodStart=0, all dutySh/dutyAct=0, periodSh=periodAct=2^N-1, modeAct=0.
- **Reset mid-operation:** outputs drop to 0 immediately (asynchronously). Operation resumes in the first cycle after deassertion with en=1.
- **Start-up latency:** from en sampled high in IDLE, the first period starts on the next edge. periodStart=1 and pwm reflects count 0 in that same cycle.
- **Output alignment:** pwm and periodStart are flops, aligned to the cycle in which the count holds the value they reflect.
- **Shadow write visibility:** a shadow write in any cycle except the load cycle becomes visible at the start of the next period.

## Structure
- Package **pwm_pkg** holds:
  - typedef enum {EDGE, CENTER} pwm_mode_t
  - typedef enum {IDLE, UP, DOWN} pwm_state_t
  - parameter-independent constants: the reset period of all ones
- Sub-module **pwm_channel**, instantiated CH times with a generate loop. Each instance holds dutySh, dutyAct and the registered compare output. Inputs: count, load, write enable (cfgWe and cfgAddr==i) and cfgData.
- The top level holds the counter FSM, the period/mode registers, load generation and periodStart.

## Test plan
- Reset, en=1, no writes → all pwm constantly 0; periodStart every 255 cycles.
- Edge mode, P=10, duties {3,0,10,15} → ch0 high 3 of 10 cycles starting with periodStart; ch1 always low; ch2 and ch3 always high; periodStart every 10 cycles.
- Center mode, P=8, ch0 D=3 → period 16 cycles; ch0 high 6 consecutive cycles spanning the boundary (last 3 cycles of the period plus first 3 cycles of the next).
- P=10, D=3; write D=7 at count 4 → current period still 3 high, next period 7 high. Write D=5 in the last cycle (count 9) → the very next period is 5 high.
- Mid-period reset pulse of 1 ns → pwm drops to 0 before the next clock edge; after release, period=255 and duty=0. en=0 or P=0 → IDLE, no periodStart, pwm=0.
- Write cfgAddr=CH+1 with data 0x55 → no register changes and outputs are undisturbed.
